buffer_register_parity_check: RTL and testbench
===============================================

# buffer_register_parity_check

Downstream consumer of the duplex buffer registers. During each 14-bit syllable shift-out it samples the serial data stream from the A and B buffer registers, checks odd parity on each side, and compares A against B bit by bit. It latches sticky error flags and saturating error counts for the error/interrupt logic, and gives a one-cycle error pulse per faulty syllable.

## Interface
Parameters:
- NBITS, 14, bits per syllable (13 data + 1 parity); counter sized for it.
- CNTW, 3, width of per-side saturating error counters.

Ports:
- SIM_CLK  in  1  simulation clock; all state updates on rising edge.
- SIM_RST  in  1  reset; synchronous, active-high.
- V1  in  1  power-good enable; 0 forces FSM to IDLE (error latches/counters hold).
- BRSTV  in  1  start strobe, 1-cycle pulse; begins a syllable window.
- BRSHV  in  1  bit strobe; one pulse per shifted bit.
- BRASD  in  1  serial data from A-side buffer register, sampled when BRSHV=1.
- BRBSD  in  1  serial data from B-side buffer register, sampled when BRSHV=1.
- CLRERV  in  1  clear all error latches and counters.
- BUSY  out  1  syllable window in progress (SHIFT or CHECK).
- PERA  out  1  sticky A-side parity error.
- PERB  out  1  sticky B-side parity error.
- DISAG  out  1  sticky A/B disagreement.
- ERRP  out  1  1-cycle pulse, any new error in the syllable just checked.
- PECNTA  out  CNTW  A-side parity error count, saturating.
- PECNTB  out  CNTW  B-side parity error count, saturating.

## Operation
- FSM states: IDLE, SHIFT, CHECK.
- IDLE: BRSTV=1 & V1=1 -> SHIFT; clear bit counter, parity accumulators (A, B), mismatch flag. BRSHV in the same cycle as BRSTV is not counted.
- SHIFT: on each BRSHV: parA ^= BRASD, parB ^= BRBSD, mism |= BRASD ^ BRBSD, count += 1. Accept when count reaches NBITS -> CHECK.
- SHIFT with BRSTV=1: abort and restart (count and accumulators cleared), no check performed, no error reported.
- CHECK (one cycle): A error if parA==0 (odd parity over all NBITS bits), same for B; disagreement if mism==1. Set corresponding sticky flags; raise ERRP if any; increment PECNTA/PECNTB per erroneous side, saturating at 2^CNTW-1. -> IDLE.
- BRSHV in CHECK or IDLE (without start) ignored.
- CLRERV: clears PERA, PERB, DISAG, PECNTA, PECNTB. When coinciding with CHECK, the new error wins: flag set, counter = 1 (or 0 if that side OK).
- V1=0 in any state: next state IDLE, accumulators discarded, no ERRP.
- Reset values: BUSY=0, PERA=0, PERB=0, DISAG=0, ERRP=0, PECNTA=0, PECNTB=0, state IDLE, count 0.

## Timing
- All outputs registered.
- BUSY rises the cycle after BRSTV is sampled; falls the cycle after CHECK.
- 14th BRSHV sampled at edge n -> CHECK during cycle n+1 -> flags/counters/ERRP visible after edge n+1 (cycle n+2 view); ERRP high exactly one cycle.
- Minimum syllable: BRSTV then NBITS consecutive BRSHV cycles -> next BRSTV accepted the cycle after CHECK (back-to-back with one idle-free gap of zero).
- SIM_RST mid-syllable: IDLE next edge; all outputs to reset values; no partial check.

## Configuration
- DUPLEX_COMPARE_EN defined: A/B mismatch accumulation and DISAG latching as above; disagreement contributes to ERRP.
- Not defined: mismatch logic removed; DISAG tied 0; ERRP driven only by parity errors.

## Test plan
- Reset, then BRSTV + 14 strobes with A=B=0x0001 (14-bit, odd) -> PERA=PERB=DISAG=0, ERRP never high, BUSY high 15 cycles.
- A=0x0003, B=0x0001 -> PERA=1, PERB=0, DISAG=1 (0 without DUPLEX_COMPARE_EN), ERRP one pulse, PECNTA=1.
- Nine consecutive bad-A syllables -> PECNTA saturates at 7; CLRERV -> all flags and counts 0.
- BRSTV asserted after 7 strobes, then a full good syllable -> no error, no ERRP from aborted window.
- CLRERV coincident with CHECK of bad-B syllable with PECNTB=5 -> PERB=1, PECNTB=1; SIM_RST at strobe 10 -> BUSY=0 next cycle, all outputs 0.

Source files
------------

// File: rtl/buffer_register_parity_check.sv
// Samples the A/B buffer-register serial streams over one syllable, checks odd parity per side
// and (with DUPLEX_COMPARE_EN defined) A/B agreement; keeps sticky flags and saturating counts.
module buffer_register_parity_check #(
  parameter int NBITS = 14,
  parameter int CNTW  = 3
) (
  input  logic            SIM_CLK,
  input  logic            SIM_RST,
  input  logic            V1,
  input  logic            BRSTV,
  input  logic            BRSHV,
  input  logic            BRASD,
  input  logic            BRBSD,
  input  logic            CLRERV,
  output logic            BUSY,
  output logic            PERA,
  output logic            PERB,
  output logic            DISAG,
  output logic            ERRP,
  output logic [CNTW-1:0] PECNTA,
  output logic [CNTW-1:0] PECNTB
);

  localparam int BCW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK} state_t;

  state_t          state_q;
  logic [BCW-1:0]  cnt_q;
  logic [BCW-1:0]  cnt_d;
  logic            par_a_q, par_b_q, mism_q;
  logic            busy_q, pera_q, perb_q, disag_q, errp_q;
  logic [CNTW-1:0] pecnta_q, pecntb_q;
  logic            start_w, shift_w, err_a_w, err_b_w, err_d_w;

  // A start strobe wins over a bit strobe in the same cycle, and restarts an open window.
  assign start_w = V1 && BRSTV && (state_q == ST_IDLE || state_q == ST_SHIFT);
  assign shift_w = V1 && BRSHV && !BRSTV && (state_q == ST_SHIFT);
  assign cnt_d   = cnt_q + BCW'(1);

  assign err_a_w = ~par_a_q;
  assign err_b_w = ~par_b_q;
  assign err_d_w = mism_q;

`ifdef DUPLEX_COMPARE_EN
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST || start_w) begin
      mism_q <= 1'b0;
    end else if (shift_w) begin
      mism_q <= mism_q | (BRASD ^ BRBSD);
    end
  end
`else
  assign mism_q = 1'b0;
`endif

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      par_a_q  <= 1'b0;
      par_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      pera_q   <= 1'b0;
      perb_q   <= 1'b0;
      disag_q  <= 1'b0;
      errp_q   <= 1'b0;
      pecnta_q <= '0;
      pecntb_q <= '0;
    end else begin
      errp_q <= 1'b0;
      if (CLRERV) begin
        pera_q   <= 1'b0;
        perb_q   <= 1'b0;
        disag_q  <= 1'b0;
        pecnta_q <= '0;
        pecntb_q <= '0;
      end
      if (!V1) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else if (start_w) begin
        state_q <= ST_SHIFT;
        busy_q  <= 1'b1;
        cnt_q   <= '0;
        par_a_q <= 1'b0;
        par_b_q <= 1'b0;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            if (shift_w) begin
              par_a_q <= par_a_q ^ BRASD;
              par_b_q <= par_b_q ^ BRBSD;
              cnt_q   <= cnt_d;
              if (cnt_d == BCW'(NBITS)) state_q <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            // Placed after the CLRERV clear so a coincident new error survives it.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            errp_q  <= err_a_w | err_b_w | err_d_w;
            if (err_a_w) begin
              pera_q   <= 1'b1;
              pecnta_q <= CLRERV ? CNTW'(1)
                        : (&pecnta_q) ? pecnta_q : pecnta_q + CNTW'(1);
            end
            if (err_b_w) begin
              perb_q   <= 1'b1;
              pecntb_q <= CLRERV ? CNTW'(1)
                        : (&pecntb_q) ? pecntb_q : pecntb_q + CNTW'(1);
            end
            if (err_d_w) disag_q <= 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign BUSY   = busy_q;
  assign PERA   = pera_q;
  assign PERB   = perb_q;
  assign DISAG  = disag_q;
  assign ERRP   = errp_q;
  assign PECNTA = pecnta_q;
  assign PECNTB = pecntb_q;

endmodule

// File: tb/tb_buffer_register_parity_check.sv
// Scoreboard bench for buffer_register_parity_check: the driver pushes the expected state at
// each window end, a monitor pops and compares when BUSY falls.
module tb_buffer_register_parity_check;
  localparam int NBITS = 14;
  localparam int CNTW  = 3;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic SIM_CLK = 1'b0;
  logic SIM_RST, V1, BRSTV, BRSHV, BRASD, BRBSD, CLRERV;
  logic BUSY, PERA, PERB, DISAG, ERRP;
  logic [CNTW-1:0] PECNTA, PECNTB;

  buffer_register_parity_check #(.NBITS(NBITS), .CNTW(CNTW)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .V1(V1), .BRSTV(BRSTV), .BRSHV(BRSHV),
    .BRASD(BRASD), .BRBSD(BRBSD), .CLRERV(CLRERV), .BUSY(BUSY), .PERA(PERA),
    .PERB(PERB), .DISAG(DISAG), .ERRP(ERRP), .PECNTA(PECNTA), .PECNTB(PECNTB)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  typedef struct packed {
    logic errp, pera, perb, disag;
    logic [CNTW-1:0] cnta, cntb;
    logic [9:0] blen;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0, fails = 0, spurious = 0;
  int dcyc = 0, win_start = 0;
  bit in_win = 0;
  int m_pera = 0, m_perb = 0, m_disag = 0, m_cnta = 0, m_cntb = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic busy_prev = 1'b0;
  int   blen = 0;
  always @(negedge SIM_CLK) begin
    exp_t e;
    if (busy_prev && !BUSY) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_window_end", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("errp",   ERRP,   e.errp);
        chk("pera",   PERA,   e.pera);
        chk("perb",   PERB,   e.perb);
        chk("disag",  DISAG,  e.disag);
        chk("pecnta", PECNTA, e.cnta);
        chk("pecntb", PECNTB, e.cntb);
        chk("busy_len", blen, e.blen);
      end
      blen = 0;
    end else if (ERRP) begin
      spurious++;
    end
    if (BUSY) blen++;
    busy_prev = BUSY;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge SIM_CLK);
    dcyc++;
  endtask

  task automatic push_exp(input bit errp, input int len);
    exp_t e;
    e.errp = errp; e.pera = m_pera[0]; e.perb = m_perb[0]; e.disag = m_disag[0];
    e.cnta = m_cnta[CNTW-1:0]; e.cntb = m_cntb[CNTW-1:0]; e.blen = len[9:0];
    exp_q.push_back(e);
  endtask

  task automatic start_window();
    if (!in_win) begin
      in_win = 1;
      win_start = dcyc;
    end
    BRSTV = 1'b1; BRSHV = 1'($urandom_range(0, 1));
    BRASD = 1'($urandom_range(0, 1)); BRBSD = 1'($urandom_range(0, 1));
    tick();
    BRSTV = 1'b0; BRSHV = 1'b0;
  endtask

  task automatic shift_bits(input logic [13:0] a, input logic [13:0] b, input int n,
                            input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) begin
        BRSHV = 1'b0; BRASD = 1'($urandom_range(0, 1)); BRBSD = 1'($urandom_range(0, 1));
        tick();
      end
      BRSHV = 1'b1; BRASD = a[i]; BRBSD = b[i];
      tick();
    end
    BRSHV = 1'b0;
  endtask

  task automatic finish_check(input logic [13:0] a, input logic [13:0] b, input bit clr);
    bit ea, eb, ed;
    ea = ($countones(a) % 2) == 0;
    eb = ($countones(b) % 2) == 0;
`ifdef DUPLEX_COMPARE_EN
    ed = (a != b);
`else
    ed = 1'b0;
`endif
    if (clr) begin m_pera = 0; m_perb = 0; m_disag = 0; m_cnta = 0; m_cntb = 0; end
    if (ea) begin m_pera = 1; m_cnta = (m_cnta < CMAX) ? m_cnta + 1 : CMAX; end
    if (eb) begin m_perb = 1; m_cntb = (m_cntb < CMAX) ? m_cntb + 1 : CMAX; end
    if (ed) m_disag = 1;
    push_exp(ea | eb | ed, dcyc - win_start);
    CLRERV = clr; BRSHV = 1'($urandom_range(0, 1));
    tick();
    CLRERV = 1'b0; BRSHV = 1'b0;
    in_win = 0;
  endtask

  task automatic syllable(input logic [13:0] a, input logic [13:0] b, input int maxgap,
                          input bit clr);
    start_window();
    shift_bits(a, b, NBITS, maxgap);
    finish_check(a, b, clr);
  endtask

  task automatic abort_then_syllable(input int k, input logic [13:0] a, input logic [13:0] b,
                                     input int maxgap);
    start_window();
    shift_bits(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), k, maxgap);
    syllable(a, b, maxgap, 1'b0);
  endtask

  task automatic reset_mid(input int k);
    start_window();
    shift_bits(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), k - 1, 0);
    m_pera = 0; m_perb = 0; m_disag = 0; m_cnta = 0; m_cntb = 0;
    push_exp(1'b0, dcyc - win_start);
    BRSHV = 1'b1; SIM_RST = 1'b1;
    tick();
    SIM_RST = 1'b0; BRSHV = 1'b0;
    in_win = 0;
  endtask

  task automatic v1_drop(input int k);
    start_window();
    shift_bits(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), k, 1);
    push_exp(1'b0, dcyc - win_start);
    V1 = 1'b0;
    tick();
    V1 = 1'b1;
    in_win = 0;
  endtask

  task automatic clear_idle();
    m_pera = 0; m_perb = 0; m_disag = 0; m_cnta = 0; m_cntb = 0;
    CLRERV = 1'b1;
    tick();
    CLRERV = 1'b0;
  endtask

  function automatic logic [13:0] rnd14();
    return 14'($urandom_range(0, 16383));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] a, b;
    SIM_RST = 1'b1; V1 = 1'b1; BRSTV = 1'b0; BRSHV = 1'b0;
    BRASD = 1'b0; BRBSD = 1'b0; CLRERV = 1'b0;
    tick(); tick(); tick();
    SIM_RST = 1'b0;
    tick();
    chk("rst_busy", BUSY, 0);   chk("rst_pera", PERA, 0);   chk("rst_perb", PERB, 0);
    chk("rst_disag", DISAG, 0); chk("rst_errp", ERRP, 0);
    chk("rst_pecnta", PECNTA, 0); chk("rst_pecntb", PECNTB, 0);

    syllable(14'h0001, 14'h0001, 0, 1'b0);
    syllable(14'h0003, 14'h0001, 0, 1'b0);
    repeat (9) syllable(14'h0003, 14'h0001, 0, 1'b0);
    clear_idle();
    syllable(14'h0001, 14'h0001, 0, 1'b0);
    abort_then_syllable(7, 14'h0001, 14'h0001, 0);
    repeat (5) syllable(14'h0001, 14'h0003, 0, 1'b0);
    syllable(14'h0001, 14'h0003, 0, 1'b1);
    reset_mid(10);
    syllable(14'h2A55, 14'h2A55, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = rnd14();
      b = ($urandom_range(0, 1) != 0) ? a : rnd14();
      case ($urandom_range(0, 9))
        7:       abort_then_syllable($urandom_range(1, NBITS - 1), a, b, 2);
        8:       v1_drop($urandom_range(0, NBITS - 1));
        9:       clear_idle();
        default: syllable(a, b, $urandom_range(0, 2), $urandom_range(0, 5) == 0);
      endcase
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("queue_drain", exp_q.size(), 0);
    chk("spurious_errp", spurious, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
